idex_pipe_reg: RTL

// - ID/EX pipeline register of the 5-stage MIPS core: captures decode-stage operands and control, presents them to the EX stage.
// - Sole producer of the ALU operand eqa and opcode ealuc; other EX-stage operands (eqb/eimm32) pass through the EX mux to the ALU.
// - Supports stall (hold), flush (bubble insert) and rejects ALU opcodes the ALU does not implement.

---
 rtl/idex_pipe_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: stall/flush/illegal-opcode handling between decode and execute.
// Optional bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module idex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              dvalid,
    input  logic              dwreg,
    input  logic              dm2reg,
    input  logic              dwmem,
    input  logic              daluimm,
    input  logic [3:0]        daluc,
    input  logic [REG_W-1:0]  drn,
    input  logic [DATA_W-1:0] dqa,
    input  logic [DATA_W-1:0] dqb,
    input  logic [DATA_W-1:0] dimm32,
    output logic              evalid,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ealuimm,
    output logic [3:0]        ealuc,
    output logic [REG_W-1:0]  ern,
    output logic [DATA_W-1:0] eqa,
    output logic [DATA_W-1:0] eqb,
    output logic [DATA_W-1:0] eimm32,
`ifdef IDEX_BUBBLE_CNT_EN
    output logic [CNT_W-1:0]  ebubble_cnt,
`endif
    output logic              eillegal
);

    localparam logic [3:0] AlucAdd = 4'b0010;

    logic              valid_q, valid_d;
    logic              wreg_q, wreg_d;
    logic              m2reg_q, m2reg_d;
    logic              wmem_q, wmem_d;
    logic              aluimm_q, aluimm_d;
    logic [3:0]        aluc_q, aluc_d;
    logic [REG_W-1:0]  rn_q, rn_d;
    logic [DATA_W-1:0] qa_q, qa_d;
    logic [DATA_W-1:0] qb_q, qb_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              illegal_q, illegal_d;
    logic              legal;
    logic              bubble_ld;

    always_comb begin
        unique case (daluc)
            4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        wreg_d    = wreg_q;
        m2reg_d   = m2reg_q;
        wmem_d    = wmem_q;
        aluimm_d  = aluimm_q;
        aluc_d    = aluc_q;
        rn_d      = rn_q;
        qa_d      = qa_q;
        qb_d      = qb_q;
        imm_d     = imm_q;
        illegal_d = 1'b0;
        bubble_ld = 1'b0;

        if (flush) begin
            bubble_ld = 1'b1;
        end else if (!stall) begin
            if (dvalid && legal) begin
                valid_d  = 1'b1;
                wreg_d   = dwreg;
                m2reg_d  = dm2reg;
                wmem_d   = dwmem;
                aluimm_d = daluimm;
                aluc_d   = daluc;
                rn_d     = drn;
                qa_d     = dqa;
                qb_d     = dqb;
                imm_d    = dimm32;
            end else begin
                // Illegal opcodes are dropped as bubbles so they never reach the ALU.
                bubble_ld = 1'b1;
                illegal_d = dvalid;
            end
        end

        if (bubble_ld) begin
            valid_d  = 1'b0;
            wreg_d   = 1'b0;
            m2reg_d  = 1'b0;
            wmem_d   = 1'b0;
            aluimm_d = 1'b0;
            aluc_d   = AlucAdd;
            rn_d     = '0;
            qa_d     = '0;
            qb_d     = '0;
            imm_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wreg_q    <= 1'b0;
            m2reg_q   <= 1'b0;
            wmem_q    <= 1'b0;
            aluimm_q  <= 1'b0;
            aluc_q    <= AlucAdd;
            rn_q      <= '0;
            qa_q      <= '0;
            qb_q      <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            wreg_q    <= wreg_d;
            m2reg_q   <= m2reg_d;
            wmem_q    <= wmem_d;
            aluimm_q  <= aluimm_d;
            aluc_q    <= aluc_d;
            rn_q      <= rn_d;
            qa_q      <= qa_d;
            qb_q      <= qb_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of bubbles loaded; stall edges load nothing and are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bubble_ld && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ebubble_cnt = cnt_q;
`endif

    assign evalid   = valid_q;
    assign ewreg    = wreg_q;
    assign em2reg   = m2reg_q;
    assign ewmem    = wmem_q;
    assign ealuimm  = aluimm_q;
    assign ealuc    = aluc_q;
    assign ern      = rn_q;
    assign eqa      = qa_q;
    assign eqb      = qb_q;
    assign eimm32   = imm_q;
    assign eillegal = illegal_q;

endmodule
